// File: rtl/uart_xcvr.sv
// uart_xcvr: parametrised full-duplex UART transceiver.
// A shared tick generator drives a transmit FSM (valid/ready handshake,
// optional parity, 1 or 2 stop bits) and an oversampling receive FSM
// (mid-bit sampling, false-start filter, framing and parity error flags).
module uart_xcvr #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [15:0]          baud_div,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err
);

  // Tick-phase counter must reach STOP_BITS*OVERSAMPLE-1 (at most 2*OVERSAMPLE-1).
  localparam int CW = $clog2(2 * OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] BIT_LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * OVERSAMPLE - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic          ODD_SENSE = 1'(PARITY_ODD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------------
  // Tick generator
  // ---------------------------------------------------------------------
  logic [15:0] tick_cnt;
  logic        tick;

  assign tick = (tick_cnt == 16'd0);

  // Down-counter: reloads baud_div on reaching zero, so a new divisor
  // only takes effect at the next reload.
  // NOTE: state registers use non-blocking (<=) assignments so every flop
  // samples the pre-edge value of the others; blocking (=) would make the
  // result depend on statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    tick_cnt <= baud_div;
    else if (tick) tick_cnt <= baud_div;
    else           tick_cnt <= tick_cnt - 16'd1;
  end

  // ---------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------
  state_t                 tx_state;
  logic [CW-1:0]          tx_cnt;
  logic [IW-1:0]          tx_idx;
  logic [DATA_BITS-1:0]   tx_shift;
  logic                   tx_par;

  // TX FSM: latches the word on acceptance, then serialises start, data
  // (LSB first), optional parity and stop bits, each OVERSAMPLE ticks long.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      txd      <= 1'b1;
      tx_ready <= 1'b1;
    end else begin
      case (tx_state)
        S_IDLE: begin
          if (tx_valid) begin
            tx_shift <= tx_data;
            tx_par   <= (^tx_data) ^ ODD_SENSE;
            txd      <= 1'b0;
            tx_ready <= 1'b0;
            tx_cnt   <= '0;
            tx_state <= S_START;
          end
        end
        S_START: begin
          if (tick) begin
            if (tx_cnt == BIT_LAST) begin
              tx_cnt   <= '0;
              tx_idx   <= '0;
              txd      <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
              tx_state <= S_DATA;
            end else begin
              tx_cnt <= tx_cnt + 1'b1;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            if (tx_cnt == BIT_LAST) begin
              tx_cnt <= '0;
              if (tx_idx == DATA_LAST) begin
                if (PARITY_EN != 0) begin
                  txd      <= tx_par;
                  tx_state <= S_PARITY;
                end else begin
                  txd      <= 1'b1;
                  tx_state <= S_STOP;
                end
              end else begin
                tx_idx   <= tx_idx + 1'b1;
                txd      <= tx_shift[0];
                tx_shift <= tx_shift >> 1;
              end
            end else begin
              tx_cnt <= tx_cnt + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (tick) begin
            if (tx_cnt == BIT_LAST) begin
              tx_cnt   <= '0;
              txd      <= 1'b1;
              tx_state <= S_STOP;
            end else begin
              tx_cnt <= tx_cnt + 1'b1;
            end
          end
        end
        S_STOP: begin
          if (tick) begin
            if (tx_cnt == STOP_LAST) begin
              tx_cnt   <= '0;
              tx_ready <= 1'b1;
              tx_state <= S_IDLE;
            end else begin
              tx_cnt <= tx_cnt + 1'b1;
            end
          end
        end
        default: begin
          txd      <= 1'b1;
          tx_ready <= 1'b1;
          tx_state <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------
  logic [1:0] rx_sync;
  logic       rx_s;

  assign rx_s = rx_sync[1];

  // Two-flop synchroniser for the asynchronous serial input; resets to the
  // idle (high) level so reset does not look like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_sync <= 2'b11;
    else        rx_sync <= {rx_sync[0], rxd};
  end

  state_t               rx_state;
  logic [CW-1:0]        rx_cnt;
  logic [IW-1:0]        rx_idx;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_par_bit;
  logic                 rx_armed;

  // RX FSM: qualifies the start bit at mid-bit, samples each following bit
  // at its centre and publishes data/flags at the stop-bit centre. After a
  // zero stop bit the line must return high before a new start is accepted,
  // so a held break reports exactly one frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state      <= S_IDLE;
      rx_cnt        <= '0;
      rx_idx        <= '0;
      rx_shift      <= '0;
      rx_par_bit    <= 1'b0;
      rx_armed      <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (rx_state)
        S_IDLE: begin
          if (rx_s) begin
            rx_armed <= 1'b1;
          end else if (rx_armed) begin
            rx_cnt   <= '0;
            rx_state <= S_START;
          end
        end
        S_START: begin
          if (tick) begin
            if (rx_cnt == HALF_LAST) begin
              rx_cnt <= '0;
              if (rx_s) begin
                rx_state <= S_IDLE;
              end else begin
                rx_idx   <= '0;
                rx_state <= S_DATA;
              end
            end else begin
              rx_cnt <= rx_cnt + 1'b1;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            if (rx_cnt == BIT_LAST) begin
              rx_cnt   <= '0;
              rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
              if (rx_idx == DATA_LAST) begin
                rx_state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
              end else begin
                rx_idx <= rx_idx + 1'b1;
              end
            end else begin
              rx_cnt <= rx_cnt + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (tick) begin
            if (rx_cnt == BIT_LAST) begin
              rx_cnt     <= '0;
              rx_par_bit <= rx_s;
              rx_state   <= S_STOP;
            end else begin
              rx_cnt <= rx_cnt + 1'b1;
            end
          end
        end
        S_STOP: begin
          if (tick) begin
            if (rx_cnt == BIT_LAST) begin
              rx_cnt        <= '0;
              rx_data       <= rx_shift;
              rx_valid      <= 1'b1;
              rx_frame_err  <= !rx_s;
              rx_parity_err <= (PARITY_EN != 0) &&
                               (((^rx_shift) ^ ODD_SENSE) != rx_par_bit);
              if (!rx_s) rx_armed <= 1'b0;
              rx_state <= S_IDLE;
            end else begin
              rx_cnt <= rx_cnt + 1'b1;
            end
          end
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_xcvr.sv
// tb_uart_xcvr: directed self-checking bench for uart_xcvr.
// Three instances: 8N1 (TX pattern, bench-driven RX, reset/loopback),
// 8E1 in loopback (back-to-back frames), 8O1 with bench-driven RX (parity).
module tb_uart_xcvr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] baud_div = 16'd0;
  logic        rxd_drv = 1'b1;
  logic        loop_n = 1'b0;

  always #5 clk = ~clk;

  // 8N1 instance
  logic [7:0] tx_data_n = 8'h00;
  logic       tx_valid_n = 1'b0;
  logic       tx_ready_n, txd_n, rxd_n;
  logic [7:0] rx_data_n;
  logic       rx_valid_n, rx_frame_err_n, rx_parity_err_n;

  assign rxd_n = loop_n ? txd_n : rxd_drv;

  uart_xcvr #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1), .OVERSAMPLE(16)) u_n (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div),
    .tx_data(tx_data_n), .tx_valid(tx_valid_n), .tx_ready(tx_ready_n), .txd(txd_n),
    .rxd(rxd_n), .rx_data(rx_data_n), .rx_valid(rx_valid_n),
    .rx_frame_err(rx_frame_err_n), .rx_parity_err(rx_parity_err_n)
  );

  // 8E1 instance, TX looped back to RX
  logic [7:0] tx_data_e = 8'h00;
  logic       tx_valid_e = 1'b0;
  logic       tx_ready_e, txd_e;
  logic [7:0] rx_data_e;
  logic       rx_valid_e, rx_frame_err_e, rx_parity_err_e;

  uart_xcvr #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1), .OVERSAMPLE(16)) u_e (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div),
    .tx_data(tx_data_e), .tx_valid(tx_valid_e), .tx_ready(tx_ready_e), .txd(txd_e),
    .rxd(txd_e), .rx_data(rx_data_e), .rx_valid(rx_valid_e),
    .rx_frame_err(rx_frame_err_e), .rx_parity_err(rx_parity_err_e)
  );

  // 8O1 instance, RX driven by the bench
  logic [7:0] tx_data_o = 8'h00;
  logic       tx_valid_o = 1'b0;
  logic       tx_ready_o, txd_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o, rx_frame_err_o, rx_parity_err_o;

  uart_xcvr #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1), .OVERSAMPLE(16)) u_o (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div),
    .tx_data(tx_data_o), .tx_valid(tx_valid_o), .tx_ready(tx_ready_o), .txd(txd_o),
    .rxd(rxd_drv), .rx_data(rx_data_o), .rx_valid(rx_valid_o),
    .rx_frame_err(rx_frame_err_o), .rx_parity_err(rx_parity_err_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // rx_valid pulse counters and per-pulse capture for the loopback instance
  int         cnt_n = 0;
  int         cnt_o = 0;
  int         cnt_e = 0;
  logic [9:0] cap_e [0:3];

  always @(negedge clk) begin
    if (rx_valid_n) cnt_n <= cnt_n + 1;
    if (rx_valid_o) cnt_o <= cnt_o + 1;
    if (rx_valid_e) begin
      if (cnt_e < 4) cap_e[cnt_e] <= {rx_parity_err_e, rx_frame_err_e, rx_data_e};
      cnt_e <= cnt_e + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one frame on rxd_drv (LSB first) followed by one idle bit.
  task automatic send_frame(input logic [7:0] data, input logic has_par, input logic par_bit,
                            input logic stop_bit, input int bit_clks);
    rxd_drv = 1'b0;
    repeat (bit_clks) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = data[i];
      repeat (bit_clks) @(negedge clk);
    end
    if (has_par) begin
      rxd_drv = par_bit;
      repeat (bit_clks) @(negedge clk);
    end
    rxd_drv = stop_bit;
    repeat (bit_clks) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (bit_clks) @(negedge clk);
  endtask

  logic [9:0] exp_bits;
  int         ready_low;
  int         pre;

  initial begin
    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    check("rst txd", 32'(txd_n), 32'd1);
    check("rst tx_ready", 32'(tx_ready_n), 32'd1);
    check("rst rx_data", 32'(rx_data_n), 32'h00);
    check("rst rx_valid", 32'(rx_valid_n), 32'd0);
    check("rst frame_err", 32'(rx_frame_err_n), 32'd0);
    check("rst parity_err", 32'(rx_parity_err_n), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("idle txd", 32'(txd_n), 32'd1);
    check("idle tx_ready", 32'(tx_ready_n), 32'd1);

    // ---------------- 1: TX waveform of 0xA5, 8N1, 16 clk per bit ----------------
    exp_bits   = {1'b1, 8'hA5, 1'b0};
    tx_data_n  = 8'hA5;
    tx_valid_n = 1'b1;
    @(posedge clk);
    #1 tx_valid_n = 1'b0;
    ready_low = 0;
    for (int b = 0; b < 10; b++) begin
      for (int k = 0; k < 16; k++) begin
        @(negedge clk);
        check($sformatf("txd bit%0d cyc%0d", b, k), 32'(txd_n), 32'(exp_bits[b]));
        if (!tx_ready_n) ready_low++;
      end
    end
    @(negedge clk);
    check("tx_ready after frame", 32'(tx_ready_n), 32'd1);
    check("tx_ready low cycles", 32'(ready_low), 32'd160);
    check("txd idle after frame", 32'(txd_n), 32'd1);

    // ---------------- 2: loopback 8E1, 0x3C then 0xFF back-to-back ----------------
    tx_data_e  = 8'h3C;
    tx_valid_e = 1'b1;
    for (int i = 0; i < 50 && tx_ready_e; i++) @(negedge clk);
    tx_data_e = 8'hFF;
    for (int i = 0; i < 400 && !tx_ready_e; i++) @(negedge clk);
    @(negedge clk);
    tx_valid_e = 1'b0;
    check("e 2nd accepted", 32'(tx_ready_e), 32'd0);
    for (int i = 0; i < 600 && cnt_e < 2; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("e pulse count", 32'(cnt_e), 32'd2);
    check("e frame0 {perr,ferr,data}", 32'(cap_e[0]), 32'h03C);
    check("e frame1 {perr,ferr,data}", 32'(cap_e[1]), 32'h0FF);

    // ---------------- 3: false start then 0x55 at baud_div=3 ----------------
    baud_div = 16'd3;
    repeat (10) @(negedge clk);
    pre = cnt_n;
    rxd_drv = 1'b0;
    repeat (16) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (300) @(negedge clk);
    check("false start no rx_valid", 32'(cnt_n), 32'(pre));
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 64);
    check("0x55 pulse count", 32'(cnt_n), 32'(pre + 1));
    check("0x55 rx_data", 32'(rx_data_n), 32'h55);
    check("0x55 frame_err", 32'(rx_frame_err_n), 32'd0);
    check("0x55 parity_err", 32'(rx_parity_err_n), 32'd0);

    // ---------------- 4: 0x81 with stop=0, then good 0xC3 ----------------
    baud_div = 16'd0;
    repeat (10) @(negedge clk);
    pre = cnt_n;
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 16);
    check("0x81 pulse count", 32'(cnt_n), 32'(pre + 1));
    check("0x81 rx_data", 32'(rx_data_n), 32'h81);
    check("0x81 frame_err", 32'(rx_frame_err_n), 32'd1);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 16);
    check("0xC3 pulse count", 32'(cnt_n), 32'(pre + 2));
    check("0xC3 rx_data", 32'(rx_data_n), 32'hC3);
    check("0xC3 frame_err cleared", 32'(rx_frame_err_n), 32'd0);

    // ---------------- 5: odd parity, 0x07 (correct parity bit = 0) ----------------
    pre = cnt_o;
    send_frame(8'h07, 1'b1, 1'b1, 1'b1, 16);
    check("o bad par pulse count", 32'(cnt_o), 32'(pre + 1));
    check("o bad par rx_data", 32'(rx_data_o), 32'h07);
    check("o bad par parity_err", 32'(rx_parity_err_o), 32'd1);
    check("o bad par frame_err", 32'(rx_frame_err_o), 32'd0);
    send_frame(8'h07, 1'b1, 1'b0, 1'b1, 16);
    check("o good par pulse count", 32'(cnt_o), 32'(pre + 2));
    check("o good par parity_err", 32'(rx_parity_err_o), 32'd0);

    // ---------------- 6: reset mid-DATA during loopback TX/RX, then 0x12 ----------------
    loop_n = 1'b1;
    repeat (4) @(negedge clk);
    tx_data_n  = 8'h12;
    tx_valid_n = 1'b1;
    @(posedge clk);
    #1 tx_valid_n = 1'b0;
    repeat (60) @(negedge clk);
    check("busy before reset", 32'(tx_ready_n), 32'd0);
    pre = cnt_n;
    rst_n = 1'b0;
    #1;
    check("async rst txd", 32'(txd_n), 32'd1);
    check("async rst tx_ready", 32'(tx_ready_n), 32'd1);
    check("async rst rx_data", 32'(rx_data_n), 32'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    check("no rx_valid after abort", 32'(cnt_n), 32'(pre));
    tx_data_n  = 8'h12;
    tx_valid_n = 1'b1;
    @(posedge clk);
    #1 tx_valid_n = 1'b0;
    for (int i = 0; i < 400 && cnt_n < pre + 1; i++) @(negedge clk);
    check("0x12 pulse count", 32'(cnt_n), 32'(pre + 1));
    check("0x12 rx_data", 32'(rx_data_n), 32'h12);
    check("0x12 frame_err", 32'(rx_frame_err_n), 32'd0);
    for (int i = 0; i < 100 && !tx_ready_n; i++) @(negedge clk);
    check("0x12 tx_ready back", 32'(tx_ready_n), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
